// File: rtl/key_entry_buffer_if.sv
// Keypad entry bus: debounced key lines and submit/backspace keys in, completed entry out.
// The master side drives keys and consumer ready; the buffer itself is the slave.
interface key_entry_buffer_if #(
    parameter int KEY_WIDTH   = 4,
    parameter int MAX_DIGITS  = 6,
    parameter int COUNT_WIDTH = 3
);
    logic [KEY_WIDTH-1:0]            keyInputValue;
    logic                            enterKey;
    logic                            backspaceKey;
    logic                            entryReady;
    logic [KEY_WIDTH*MAX_DIGITS-1:0] keyValueStore;
    logic [COUNT_WIDTH-1:0]          keyNumbersStore;
    logic                            entryValid;
    logic                            timeValueFlag;

    modport master (
        output keyInputValue, enterKey, backspaceKey, entryReady,
        input  keyValueStore, keyNumbersStore, entryValid, timeValueFlag
    );

    modport slave (
        input  keyInputValue, enterKey, backspaceKey, entryReady,
        output keyValueStore, keyNumbersStore, entryValid, timeValueFlag
    );
endinterface

// File: rtl/key_entry_buffer.sv
// Keypad entry collector for the digital lock: edge-detects presses, buffers codes with
// backspace, submits on enter or when full, and abandons an entry after inactivity.
module key_entry_buffer #(
    parameter int KEY_WIDTH       = 4,
    parameter int MAX_DIGITS      = 6,
    parameter int COUNT_WIDTH     = 3,
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int TIMEOUT_MS      = 1000,
    parameter int TIMER_WIDTH     = 32,
    parameter int AUTO_SUBMIT     = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    key_entry_buffer_if.slave entry_bus
);
    localparam int STORE_W        = KEY_WIDTH * MAX_DIGITS;
    localparam int TIMEOUT_CYCLES = CLOCK_FREQUENCY / 1000 * TIMEOUT_MS;

    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE      = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_LAST     = COUNT_WIDTH'(MAX_DIGITS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ENTRY  = 2'd1;
    localparam logic [1:0] S_FULL   = 2'd2;
    localparam logic [1:0] S_SUBMIT = 2'd3;

    logic [1:0]             r_state;
    logic [STORE_W-1:0]     r_store;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_valid;
    logic                   r_flag;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic [KEY_WIDTH-1:0]   r_key_prev;
    logic                   r_enter_prev;
    logic                   r_bs_prev;

    logic                   w_digit_evt;
    logic                   w_enter_evt;
    logic                   w_bs_evt;
    logic                   w_active;
    logic                   w_handshake;
    logic                   w_timeout;

    logic [1:0]             w_state_nx;
    logic [STORE_W-1:0]     w_store_nx;
    logic [COUNT_WIDTH-1:0] w_count_nx;
    logic                   w_valid_nx;
    logic                   w_flag_nx;
    logic [TIMER_WIDTH-1:0] w_timer_nx;

    // A held key or button yields one event: only the transition away from idle counts.
    assign w_digit_evt = (entry_bus.keyInputValue != '0) && (r_key_prev == '0);
    assign w_enter_evt = entry_bus.enterKey && !r_enter_prev;
    assign w_bs_evt    = entry_bus.backspaceKey && !r_bs_prev;

    assign w_active    = (r_state == S_ENTRY) || (r_state == S_FULL);
    assign w_handshake = r_valid && entry_bus.entryReady;
    assign w_timeout   = w_active && (r_timer == TIMEOUT_LAST);

    // The if-chain order is the same-cycle priority; a taken branch discards the rest.
    always_comb begin
        w_state_nx = r_state;
        w_store_nx = r_store;
        w_count_nx = r_count;
        w_valid_nx = r_valid;
        w_flag_nx  = r_flag;
        w_timer_nx = w_active ? r_timer + 1'b1 : '0;

        if (w_handshake) begin
            w_state_nx = S_IDLE;
            w_store_nx = '0;
            w_count_nx = '0;
            w_valid_nx = 1'b0;
        end else if (w_timeout) begin
            w_state_nx = S_IDLE;
            w_store_nx = '0;
            w_count_nx = '0;
            w_flag_nx  = 1'b1;
            w_timer_nx = '0;
        end else if (w_enter_evt && w_active) begin
            w_state_nx = S_SUBMIT;
            w_valid_nx = 1'b1;
            w_timer_nx = '0;
        end else if (w_bs_evt && w_active) begin
            w_store_nx = r_store >> KEY_WIDTH;
            w_count_nx = r_count - 1'b1;
            w_state_nx = (r_count == CNT_ONE) ? S_IDLE : S_ENTRY;
            w_timer_nx = '0;
        end else if (w_digit_evt && (r_state == S_FULL)) begin
            // Overflow press abandons the whole entry; the extra code is dropped.
            w_state_nx = S_IDLE;
            w_store_nx = '0;
            w_count_nx = '0;
            w_flag_nx  = 1'b0;
            w_timer_nx = '0;
        end else if (w_digit_evt && (r_state != S_SUBMIT)) begin
            w_store_nx = (r_store << KEY_WIDTH) | STORE_W'(entry_bus.keyInputValue);
            w_count_nx = r_count + 1'b1;
            w_flag_nx  = 1'b0;
            w_timer_nx = '0;
            if (r_count == CNT_LAST) begin
                if (AUTO_SUBMIT != 0) begin
                    w_state_nx = S_SUBMIT;
                    w_valid_nx = 1'b1;
                end else begin
                    w_state_nx = S_FULL;
                end
            end else begin
                w_state_nx = S_ENTRY;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_store      <= '0;
            r_count      <= '0;
            r_valid      <= 1'b0;
            r_flag       <= 1'b0;
            r_timer      <= '0;
            r_key_prev   <= '0;
            r_enter_prev <= 1'b0;
            r_bs_prev    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_store      <= w_store_nx;
            r_count      <= w_count_nx;
            r_valid      <= w_valid_nx;
            r_flag       <= w_flag_nx;
            r_timer      <= w_timer_nx;
            r_key_prev   <= entry_bus.keyInputValue;
            r_enter_prev <= entry_bus.enterKey;
            r_bs_prev    <= entry_bus.backspaceKey;
        end
    end

    assign entry_bus.keyValueStore   = r_store;
    assign entry_bus.keyNumbersStore = r_count;
    assign entry_bus.entryValid      = r_valid;
    assign entry_bus.timeValueFlag   = r_flag;
endmodule

// File: tb/tb_key_entry_buffer.sv
// Directed bench for key_entry_buffer: one instance waits for enter, one auto-submits when full.
module tb_key_entry_buffer;
    logic clock;
    logic reset_n;
    int   vectors;
    int   miscompares;

    key_entry_buffer_if #(.KEY_WIDTH(4), .MAX_DIGITS(6), .COUNT_WIDTH(3)) bus0 ();
    key_entry_buffer_if #(.KEY_WIDTH(4), .MAX_DIGITS(6), .COUNT_WIDTH(3)) bus1 ();

    key_entry_buffer #(
        .KEY_WIDTH(4), .MAX_DIGITS(6), .COUNT_WIDTH(3), .CLOCK_FREQUENCY(50_000),
        .TIMEOUT_MS(1), .TIMER_WIDTH(32), .AUTO_SUBMIT(0)
    ) u_dut_manual (
        .clock(clock), .reset_n(reset_n), .entry_bus(bus0)
    );

    key_entry_buffer #(
        .KEY_WIDTH(4), .MAX_DIGITS(6), .COUNT_WIDTH(3), .CLOCK_FREQUENCY(50_000),
        .TIMEOUT_MS(1), .TIMER_WIDTH(32), .AUTO_SUBMIT(1)
    ) u_dut_auto (
        .clock(clock), .reset_n(reset_n), .entry_bus(bus1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input bit sel, input logic [23:0] st,
                                input logic [2:0] cnt, input logic v, input logic f);
        logic [23:0] o_st;
        logic [2:0]  o_cnt;
        logic        o_v;
        logic        o_f;
        if (sel) begin
            o_st = bus1.keyValueStore; o_cnt = bus1.keyNumbersStore;
            o_v  = bus1.entryValid;    o_f   = bus1.timeValueFlag;
        end else begin
            o_st = bus0.keyValueStore; o_cnt = bus0.keyNumbersStore;
            o_v  = bus0.entryValid;    o_f   = bus0.timeValueFlag;
        end
        check({tag, "/store"}, 32'(o_st), 32'(st));
        check({tag, "/count"}, 32'(o_cnt), 32'(cnt));
        check({tag, "/valid"}, 32'(o_v), 32'(v));
        check({tag, "/tflag"}, 32'(o_f), 32'(f));
    endtask

    task automatic drive_key(input bit sel, input logic [3:0] k);
        if (sel) bus1.keyInputValue = k;
        else     bus0.keyInputValue = k;
    endtask

    task automatic press(input bit sel, input logic [3:0] k);
        drive_key(sel, k);
        tick(10);
        drive_key(sel, 4'h0);
        tick(2);
    endtask

    task automatic button(input bit is_enter);
        if (is_enter) bus0.enterKey = 1'b1;
        else          bus0.backspaceKey = 1'b1;
        tick(10);
        bus0.enterKey     = 1'b0;
        bus0.backspaceKey = 1'b0;
        tick(2);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        bus0.keyInputValue = '0; bus0.enterKey = 1'b0; bus0.backspaceKey = 1'b0; bus0.entryReady = 1'b0;
        bus1.keyInputValue = '0; bus1.enterKey = 1'b0; bus1.backspaceKey = 1'b0; bus1.entryReady = 1'b0;
        tick(3);
        expect_state("reset_m", 1'b0, 24'h0, 3'd0, 1'b0, 1'b0);
        expect_state("reset_a", 1'b1, 24'h0, 3'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick(1);

        // Fill the manual buffer, then overflow it
        press(0, 4'h1);
        expect_state("first_press", 1'b0, 24'h1, 3'd1, 1'b0, 1'b0);
        press(0, 4'h2); press(0, 4'h8); press(0, 4'h4); press(0, 4'h8); press(0, 4'h2);
        expect_state("full", 1'b0, 24'h128482, 3'd6, 1'b0, 1'b0);
        press(0, 4'h1);
        expect_state("overflow", 1'b0, 24'h0, 3'd0, 1'b0, 1'b0);

        // Backspace, including one in IDLE
        press(0, 4'h3); press(0, 4'h5);
        button(1'b0);
        expect_state("bs_one", 1'b0, 24'h3, 3'd1, 1'b0, 1'b0);
        button(1'b0);
        expect_state("bs_empty", 1'b0, 24'h0, 3'd0, 1'b0, 1'b0);
        button(1'b0);
        expect_state("bs_idle", 1'b0, 24'h0, 3'd0, 1'b0, 1'b0);

        // Enter with consumer stalled; a press during SUBMIT is ignored
        press(0, 4'h1); press(0, 4'h2); press(0, 4'h3);
        bus0.enterKey = 1'b1;
        tick(1);
        expect_state("enter_edge", 1'b0, 24'h123, 3'd3, 1'b1, 1'b0);
        bus0.enterKey      = 1'b0;
        bus0.keyInputValue = 4'h4;
        tick(4);
        expect_state("submit_hold", 1'b0, 24'h123, 3'd3, 1'b1, 1'b0);
        bus0.keyInputValue = 4'h0;
        bus0.entryReady    = 1'b1;
        tick(1);
        expect_state("handshake", 1'b0, 24'h0, 3'd0, 1'b0, 1'b0);
        bus0.entryReady = 1'b0;
        tick(2);

        // Auto-submit instance
        press(1, 4'h1); press(1, 4'h2); press(1, 4'h8); press(1, 4'h4); press(1, 4'h8);
        expect_state("auto_five", 1'b1, 24'h12848, 3'd5, 1'b0, 1'b0);
        drive_key(1, 4'h2);
        tick(1);
        expect_state("auto_sixth", 1'b1, 24'h128482, 3'd6, 1'b1, 1'b0);
        tick(9);
        drive_key(1, 4'h0);
        tick(2);
        expect_state("auto_wait", 1'b1, 24'h128482, 3'd6, 1'b1, 1'b0);
        bus1.entryReady = 1'b1;
        tick(1);
        expect_state("auto_hs", 1'b1, 24'h0, 3'd0, 1'b0, 1'b0);
        bus1.entryReady = 1'b0;

        // Timeout fires on the 50th edge after the accepted press
        press(0, 4'h7);
        tick(38);
        expect_state("pre_timeout", 1'b0, 24'h7, 3'd1, 1'b0, 1'b0);
        tick(1);
        expect_state("timeout", 1'b0, 24'h0, 3'd0, 1'b0, 1'b1);
        press(0, 4'h9);
        expect_state("after_to", 1'b0, 24'h9, 3'd1, 1'b0, 1'b0);

        // Asynchronous reset while an entry is offered
        button(1'b1);
        expect_state("submit_9", 1'b0, 24'h9, 3'd1, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        expect_state("async_rst", 1'b0, 24'h0, 3'd0, 1'b0, 1'b0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        press(0, 4'h1);
        expect_state("post_rst", 1'b0, 24'h1, 3'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/key_entry_buffer.md
# key_entry_buffer

Parametrised keypad entry collector for the digital lock. It takes keypad input that has already been debounced and is synchronous to the clock, and detects one press per key-down edge. Pressed codes are shifted into a buffer of `MAX_DIGITS` entries. The block supports backspace, explicit or automatic submit, and an inactivity timeout. A completed entry is offered to the lock FSM through a valid/ready handshake.

## Interface
- `KEY_WIDTH`, 4: number of key lines; each stored code is the raw `KEY_WIDTH`-bit pattern.
- `MAX_DIGITS`, 6: buffer depth, in codes.
- `COUNT_WIDTH`, 3: width of the digit counter; must hold `MAX_DIGITS`.
- `CLOCK_FREQUENCY`, 50_000_000: clock frequency, in Hz.
- `TIMEOUT_MS`, 1000: inactivity timeout, in ms. `TIMEOUT_CYCLES` = `CLOCK_FREQUENCY`/1000*`TIMEOUT_MS`.
- `TIMER_WIDTH`, 32: width of the timeout counter; must hold `TIMEOUT_CYCLES`.
- `AUTO_SUBMIT`, 0: 1 = submit automatically when the buffer fills; 0 = wait for `enterKey`.

- `clock`  in  1  single system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `keyInputValue`  in  `KEY_WIDTH`  digit key lines; all-zero means no key.
- `enterKey`  in  1  submit key, level input.
- `backspaceKey`  in  1  delete-last key, level input.
- `entryReady`  in  1  consumer ready for the entry.
- `keyValueStore`  out  `KEY_WIDTH*MAX_DIGITS`  buffer; newest code in the LSBs, unused upper entries zero.
- `keyNumbersStore`  out  `COUNT_WIDTH`  number of codes held.
- `entryValid`  out  1  entry offered to the consumer.
- `timeValueFlag`  out  1  sticky inactivity-timeout flag.

## Operation
- Press detection:
  - The block registers `keyPrev`, `enterPrev` and `bsPrev`.
  - digitEvt = `keyInputValue`!=0 && `keyPrev`==0. The code is captured from `keyInputValue` on that same cycle.
  - enterEvt and bsEvt are the 0→1 edges of `enterKey` and `backspaceKey`.
  - A held key produces exactly one event.
- States:
  - IDLE: count 0.
  - ENTRY: 0 < count < `MAX_DIGITS`.
  - FULL: count = `MAX_DIGITS`; only reachable with `AUTO_SUBMIT`=0.
  - SUBMIT.
- digitEvt in IDLE or ENTRY:
  - store <= (store << `KEY_WIDTH`) | code; count++.
  - When count reaches `MAX_DIGITS`: go to SUBMIT if `AUTO_SUBMIT`=1, else to FULL.
- digitEvt in FULL (overflow press): clear store and count, go to IDLE. The code is discarded.
- bsEvt in ENTRY or FULL:
  - store <= store >> `KEY_WIDTH`; count--.
  - Go to IDLE if the new count is 0, else ENTRY.
  - bsEvt in IDLE is ignored.
- enterEvt in ENTRY or FULL: go to SUBMIT. enterEvt in IDLE is ignored.
- SUBMIT:
  - `entryValid`=1; store and count are frozen.
  - digitEvt, bsEvt, enterEvt and timeout are all ignored.
  - On an edge where `entryValid`&&`entryReady`: clear store and count, go to IDLE.
- Timeout:
  - The timer resets to 0 on every accepted event and is held at 0 in IDLE and SUBMIT.
  - Otherwise it increments each cycle.
  - On reaching `TIMEOUT_CYCLES`-1: clear store and count, go to IDLE, set `timeValueFlag`.
- `timeValueFlag` clears on the next digitEvt. That press is accepted as the first code of a new entry.
- Same-cycle priority, highest first:
  1. reset
  2. handshake completion
  3. timeout
  4. enterEvt
  5. bsEvt
  6. digitEvt

  Lower-priority events in that cycle are discarded; their edge registers still update.

## Timing
- Reset values: `keyValueStore`=0, `keyNumbersStore`=0, `entryValid`=0, `timeValueFlag`=0; state IDLE; timer and edge registers 0.
- Reset acts immediately, including in mid-entry and in SUBMIT.
- Latency: an input first sampled high at edge E updates the outputs at edge E (visible after E). All outputs are registered.
- `entryValid` rises at the edge that accepts enterEvt, or the `MAX_DIGITS`-th digitEvt when `AUTO_SUBMIT`=1.
- `entryValid` falls at the handshake edge. `keyValueStore` and `keyNumbersStore` read 0 from that edge on.
- `entryValid` must not drop without a handshake; `entryReady` may be high before `entryValid`.
- Timeout fires exactly `TIMEOUT_CYCLES` edges after the last accepted event, provided no event intervenes.

## Test plan
Benches use `CLOCK_FREQUENCY`=50_000 and `TIMEOUT_MS`=1, giving `TIMEOUT_CYCLES`=50. Each key is held 10 cycles, with 2 idle cycles between keys (total gap < 50).
1. `AUTO_SUBMIT`=0; press 1,2,8,4,8,2 → store 0x128482, count 6, `entryValid` 0. A seventh press of 1 → store 0, count 0.
2. Press 3, 5, then backspace → store 0x3, count 1. Backspace twice more → store 0, count 0; the second press is ignored without error.
3. Press 1,2,3, then enter with `entryReady`=0 for 5 cycles → `entryValid` 1, store 0x123; a press of 4 during this time is ignored. Raise `entryReady` → at that edge `entryValid` 0, store 0, count 0.
4. `AUTO_SUBMIT`=1; six presses → `entryValid` rises at the sixth-press edge, store 0x128482. Handshake → cleared.
5. Press 7, then idle 50 cycles → store 0, count 0, `timeValueFlag` 1. Press 9 → flag 0, store 0x9, count 1.
6. Assert `reset_n`=0 mid-cycle while in SUBMIT → all outputs 0 without waiting for a clock edge. After release, press 1 → store 0x1.
